// File: rtl/pluto_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pluto_pkg
//  Purpose  : Shared constants, the channel state type and duty-word helpers
//             for the pluto_servo PWM scheduler.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package pluto_pkg;

    localparam int PWM_TOP   = 2046;   // terminal count, period = PWM_TOP+1 clocks
    localparam int PWM_CNT_W = 11;     // period counter width
    localparam int SIGN_BIT  = 15;     // duty word direction bit (1 = down)
    localparam int MAG_MSB   = 10;     // duty word magnitude is [MAG_MSB:0]
    localparam int DUTY_W    = 16;     // duty word width

    // Per-channel reversal state machine
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HOLD = 1'b1
    } chan_state_t;

    // True when the magnitude field of a duty word is non-zero
    function automatic logic mag_nz(input logic [DUTY_W-1:0] d);
        return |d[MAG_MSB:0];
    endfunction

    // True when moving from cur to nxt is a direction reversal that needs a
    // zero-magnitude dwell (a stopped output can flip sign freely)
    function automatic logic needs_hold(input logic [DUTY_W-1:0] cur,
                                        input logic [DUTY_W-1:0] nxt);
        return (cur[SIGN_BIT] != nxt[SIGN_BIT]) && mag_nz(cur);
    endfunction

endpackage : pluto_pkg
`default_nettype wire

// File: rtl/pluto_pwm_chan.sv
`default_nettype none
// ============================================================================
//  Module   : pluto_pwm_chan
//  Purpose  : One PWM channel: shadow, target and active duty registers plus
//             the RUN/HOLD reversal state machine.
//  Ports    : clk, nReset     clock, async active-low reset
//             wr_en, wr_data  shadow register write
//             wrap            period wrap edge qualifier
//             apply           wrap edge on which a commit takes effect
//             force_zero      watchdog trip: zero output, back to RUN
//             active          duty word presented to the comparators
//  Revision : 1.0  initial release
// ============================================================================
module pluto_pwm_chan
    import pluto_pkg::*;
#(
    parameter int REV_HOLD = 2
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              wr_en,
    input  logic [DUTY_W-1:0] wr_data,
    input  logic              wrap,
    input  logic              apply,
    input  logic              force_zero,
    output logic [DUTY_W-1:0] active
);

    localparam int HOLD_W = (REV_HOLD < 1) ? 1 : $clog2(REV_HOLD + 1);
    localparam logic [HOLD_W-1:0] C_HOLD_LOAD = HOLD_W'(REV_HOLD);

    chan_state_t        r_state,  w_state;
    logic [DUTY_W-1:0]  r_shadow;
    logic [DUTY_W-1:0]  r_target, w_target;
    logic [DUTY_W-1:0]  r_active, w_active;
    logic [HOLD_W-1:0]  r_hold,   w_hold;
    logic [DUTY_W-1:0]  w_latest;

    // Target as it stands after this edge; an apply on the final hold edge
    // must be honoured, so the fresh shadow wins over the stored target.
    assign w_latest = apply ? r_shadow : r_target;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state  <= RUN;
            r_shadow <= '0;
            r_target <= '0;
            r_active <= '0;
            r_hold   <= '0;
        end else begin
            r_state  <= w_state;
            r_target <= w_target;
            r_active <= w_active;
            r_hold   <= w_hold;
            if (wr_en) begin
                r_shadow <= wr_data;
            end
        end
    end

    always_comb begin
        w_state  = r_state;
        w_target = r_target;
        w_active = r_active;
        w_hold   = r_hold;
        if (force_zero) begin
            w_active = '0;
            w_hold   = '0;
            w_state  = RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (apply) begin
                        w_target = r_shadow;
                        if (needs_hold(r_active, r_shadow)) begin
                            // Keep the old direction, drop the magnitude
                            w_active = {r_active[DUTY_W-1:MAG_MSB+1], {(MAG_MSB+1){1'b0}}};
                            w_hold   = C_HOLD_LOAD;
                            w_state  = HOLD;
                        end else begin
                            w_active = r_shadow;
                        end
                    end
                end
                HOLD: begin
                    if (apply) begin
                        w_target = r_shadow;
                    end
                    if (wrap) begin
                        // The hold always runs to completion, whatever the
                        // sign of the latest target.
                        if (r_hold <= HOLD_W'(1)) begin
                            w_hold   = '0;
                            w_active = w_latest;
                            w_state  = RUN;
                        end else begin
                            w_hold = r_hold - HOLD_W'(1);
                        end
                    end
                end
                default: begin
                    w_state = RUN;
                end
            endcase
        end
    end

    assign active = r_active;

endmodule : pluto_pwm_chan
`default_nettype wire

// File: rtl/pluto_pwm_sched.sv
`default_nettype none
// ============================================================================
//  Module   : pluto_pwm_sched
//  Purpose  : PWM period counter, commit scheduling and host-loss watchdog
//             for the four-channel pluto_servo PWM datapath.
//  Ports    : clk, nReset          clock, async active-low reset
//             wr_stb/wr_ch/wr_data shadow register write
//             commit               end of host update frame
//             wdog_en, clr_trip    watchdog control
//             pwmcnt, period_start period counter to the comparators
//             pwm_out              active duty words, channel n at [16n+15:16n]
//             pending, wdog_trip   status
//  Revision : 1.0  initial release
// ============================================================================
module pluto_pwm_sched
    import pluto_pkg::*;
#(
    parameter int NCH          = 4,
    parameter int CNT_W        = PWM_CNT_W,
    parameter int TOP          = PWM_TOP,
    parameter int REV_HOLD     = 2,
    parameter int WDOG_PERIODS = 200
) (
    input  logic                  clk,
    input  logic                  nReset,
    input  logic                  wr_stb,
    input  logic [1:0]            wr_ch,
    input  logic [DUTY_W-1:0]     wr_data,
    input  logic                  commit,
    input  logic                  wdog_en,
    input  logic                  clr_trip,
    output logic [CNT_W-1:0]      pwmcnt,
    output logic                  period_start,
    output logic [NCH*DUTY_W-1:0] pwm_out,
    output logic                  pending,
    output logic                  wdog_trip
);

    localparam int WD_W = $clog2(WDOG_PERIODS + 1);
    localparam logic [CNT_W-1:0] C_TOP       = CNT_W'(TOP);
    localparam logic [WD_W-1:0]  C_WD_LAST   = WD_W'(WDOG_PERIODS - 1);
    localparam logic [WD_W-1:0]  C_WD_LIMIT  = WD_W'(WDOG_PERIODS);

    logic [CNT_W-1:0] r_cnt;
    logic [WD_W-1:0]  r_wcnt;
    logic             r_pending;
    logic             r_trip;

    logic w_wrap;
    logic w_commit_eff;
    logic w_trip_evt;
    logic w_apply;

    assign w_wrap = (r_cnt == C_TOP);

    // A clear on the same edge as a commit is processed first, so the
    // commit is honoured even though the trip flag is still set.
    assign w_commit_eff = commit && (!r_trip || clr_trip);

    assign w_trip_evt = wdog_en && w_wrap && !r_trip && !clr_trip &&
                        !w_commit_eff && (r_wcnt == C_WD_LAST);

    // Only the registered pending counts, so a commit in the TOP cycle waits
    // one more period.
    assign w_apply = w_wrap && r_pending && !r_trip;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_wcnt <= '0;
            r_trip <= 1'b0;
        end else begin
            if (!wdog_en || clr_trip || w_commit_eff) begin
                r_wcnt <= '0;
            end else if (w_trip_evt) begin
                r_wcnt <= C_WD_LIMIT;
            end else if (w_wrap && !r_trip) begin
                r_wcnt <= r_wcnt + WD_W'(1);
            end
            if (clr_trip) begin
                r_trip <= 1'b0;
            end else if (w_trip_evt) begin
                r_trip <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_pending <= 1'b0;
        end else if (w_trip_evt) begin
            r_pending <= 1'b0;
        end else if (w_commit_eff) begin
            r_pending <= 1'b1;
        end else if (w_apply) begin
            r_pending <= 1'b0;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        pluto_pwm_chan #(
            .REV_HOLD (REV_HOLD)
        ) u_chan (
            .clk        (clk),
            .nReset     (nReset),
            .wr_en      (wr_stb && (wr_ch == 2'(i))),
            .wr_data    (wr_data),
            .wrap       (w_wrap),
            .apply      (w_apply),
            .force_zero (w_trip_evt),
            .active     (pwm_out[DUTY_W*i +: DUTY_W])
        );
    end

    assign pwmcnt       = r_cnt;
    assign period_start = (r_cnt == '0);
    assign pending      = r_pending;
    assign wdog_trip    = r_trip;

endmodule : pluto_pwm_sched
`default_nettype wire

// File: tb/tb_pluto_pwm_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pluto_pwm_sched
//  Purpose  : Directed self-checking bench for pluto_pwm_sched.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pluto_pwm_sched;

    localparam int NCH  = 4;
    localparam int TOP  = 2046;
    localparam int PER  = TOP + 1;

    logic              clk = 1'b0;
    logic              nReset;
    logic              wr_stb;
    logic [1:0]        wr_ch;
    logic [15:0]       wr_data;
    logic              commit;
    logic              wdog_en;
    logic              clr_trip;
    logic [10:0]       pwmcnt;
    logic              period_start;
    logic [NCH*16-1:0] pwm_out;
    logic              pending;
    logic              wdog_trip;

    int n_tests = 0;
    int n_fail  = 0;

    pluto_pwm_sched #(
        .NCH          (NCH),
        .CNT_W        (11),
        .TOP          (TOP),
        .REV_HOLD     (2),
        .WDOG_PERIODS (3)
    ) u_dut (
        .clk          (clk),
        .nReset       (nReset),
        .wr_stb       (wr_stb),
        .wr_ch        (wr_ch),
        .wr_data      (wr_data),
        .commit       (commit),
        .wdog_en      (wdog_en),
        .clr_trip     (clr_trip),
        .pwmcnt       (pwmcnt),
        .period_start (period_start),
        .pwm_out      (pwm_out),
        .pending      (pending),
        .wdog_trip    (wdog_trip)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] ch, input logic [15:0] d);
        wr_stb  = 1'b1;
        wr_ch   = ch;
        wr_data = d;
        step();
        wr_stb  = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        step();
        commit = 1'b0;
    endtask

    task automatic wait_cnt(input int v);
        int n;
        n = 0;
        while (int'(pwmcnt) != v && n < PER + 50) begin
            step();
            n++;
        end
        if (int'(pwmcnt) != v) chk("wait_cnt_timeout", 64'(pwmcnt), 64'(v));
    endtask

    // Advance through the next wrap edge; returns with pwmcnt == 0
    task automatic next_wrap();
        wait_cnt(TOP);
        step();
    endtask

    function automatic logic [15:0] ch(input int n);
        return pwm_out[16*n +: 16];
    endfunction

    initial begin
        nReset   = 1'b1;
        wr_stb   = 1'b0;
        wr_ch    = '0;
        wr_data  = '0;
        commit   = 1'b0;
        wdog_en  = 1'b0;
        clr_trip = 1'b0;
        #1 nReset = 1'b0;
        #2;
        chk("rst_pwmcnt",   64'(pwmcnt), 64'd0);
        chk("rst_pwm_out",  pwm_out, 64'd0);
        chk("rst_pending",  64'(pending), 64'd0);
        chk("rst_trip",     64'(wdog_trip), 64'd0);
        chk("rst_pstart",   64'(period_start), 64'd1);
        step();
        step();
        nReset = 1'b1;

        // Shadow write with no commit never reaches the output
        wr(2'd0, 16'h0400);
        repeat (3 * PER) step();
        chk("nocommit_ch0",     64'(ch(0)), 64'h0);
        chk("nocommit_pending", 64'(pending), 64'd0);

        // Mid-period commit, both channels appear on the same wrap
        wr(2'd1, 16'h8200);
        wait_cnt(500);
        do_commit();
        chk("commit_pending1", 64'(pending), 64'd1);
        wait_cnt(TOP);
        chk("commit_before_wrap", pwm_out, 64'h0);
        step();
        chk("commit_cnt0",   64'(pwmcnt), 64'd0);
        chk("commit_pstart", 64'(period_start), 64'd1);
        chk("commit_ch0",    64'(ch(0)), 64'h0400);
        chk("commit_ch1",    64'(ch(1)), 64'h8200);
        chk("commit_pending0", 64'(pending), 64'd0);

        // Commit in the TOP cycle waits one full period
        wr(2'd3, 16'h0123);
        wait_cnt(TOP);
        commit = 1'b1;
        step();
        commit = 1'b0;
        chk("topcommit_pending", 64'(pending), 64'd1);
        chk("topcommit_ch3_old", 64'(ch(3)), 64'h0);
        next_wrap();
        chk("topcommit_ch3_new", 64'(ch(3)), 64'h0123);
        chk("topcommit_pend0",   64'(pending), 64'd0);

        // Direction reversal on ch2: two zero periods, then the new value
        wr(2'd2, 16'h0300);
        do_commit();
        next_wrap();
        chk("rev_ch2_init", 64'(ch(2)), 64'h0300);
        wr(2'd2, 16'h8300);
        do_commit();
        next_wrap();
        chk("rev_hold_p1", 64'(ch(2)), 64'h0000);
        chk("rev_ch1_same", 64'(ch(1)), 64'h8200);
        next_wrap();
        chk("rev_hold_p2", 64'(ch(2)), 64'h0000);
        next_wrap();
        chk("rev_done", 64'(ch(2)), 64'h8300);

        // Watchdog: trips on the third wrap without a commit
        wdog_en = 1'b1;
        next_wrap();
        next_wrap();
        chk("wd_not_yet", 64'(wdog_trip), 64'd0);
        chk("wd_out_kept", pwm_out, 64'h0123_8300_8200_0400);
        next_wrap();
        chk("wd_tripped", 64'(wdog_trip), 64'd1);
        chk("wd_zeroed",  pwm_out, 64'h0);
        do_commit();
        chk("wd_commit_ignored", 64'(pending), 64'd0);
        next_wrap();
        chk("wd_still_zero", pwm_out, 64'h0);
        chk("wd_still_trip", 64'(wdog_trip), 64'd1);
        clr_trip = 1'b1;
        step();
        clr_trip = 1'b0;
        chk("wd_cleared", 64'(wdog_trip), 64'd0);
        chk("wd_clr_out0", pwm_out, 64'h0);
        do_commit();
        chk("wd_clr_pending", 64'(pending), 64'd1);
        next_wrap();
        chk("wd_reapply", pwm_out, 64'h0123_8300_8200_0400);
        wdog_en = 1'b0;

        // Async reset in the middle of a reversal hold
        wr(2'd2, 16'h0100);
        do_commit();
        next_wrap();
        chk("hold_old_sign", 64'(ch(2)), 64'h8000);
        wait_cnt(1000);
        do_commit();
        #2 nReset = 1'b0;
        #1;
        chk("arst_pwmcnt",  64'(pwmcnt), 64'd0);
        chk("arst_pwm_out", pwm_out, 64'h0);
        chk("arst_pending", 64'(pending), 64'd0);
        chk("arst_trip",    64'(wdog_trip), 64'd0);
        step();
        nReset = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pluto_pwm_sched
`default_nettype wire
